// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between a design port and a Wishbone slave.
// Define SRAM_ARB_STARVE_EN to let Wishbone through after STARVE_LIMIT design grants.
module sram_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       des_en_i,
   input  logic       des_req_i,
   input  logic       des_we_i,
   input  logic [5:0] des_addr_i,
   input  logic [7:0] des_wdata_i,
   output logic [7:0] des_rdata_o,
   output logic       des_ack_o,
   input  logic       wbs_cyc_i,
   input  logic       wbs_stb_i,
   input  logic       wbs_we_i,
   input  logic [5:0] wbs_adr_i,
   input  logic [7:0] wbs_dat_i,
   output logic [7:0] wbs_dat_o,
   output logic       wbs_ack_o,
   output logic       sram_cen_o,
   output logic       sram_gwen_o,
   output logic [5:0] sram_a_o,
   output logic [7:0] sram_d_o,
   input  logic [7:0] sram_q_i
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state_q, state_d;
   logic des_vld, wb_vld, grant, grant_wb;
   logic owner_q, we_q;
   logic [5:0] addr_q;
   logic [7:0] wdata_q, des_rdata_q, wbs_rdata_q;
   assign des_vld = des_en_i & des_req_i;
   assign wb_vld = wbs_cyc_i & wbs_stb_i;
   assign grant = (state_q == IDLE) & (des_vld | wb_vld);
`ifdef SRAM_ARB_STARVE_EN
   logic [3:0] cnt_q, cnt_d;
   assign grant_wb = wb_vld & (~des_vld | (cnt_q == 4'(STARVE_LIMIT)));
   always_comb cnt_d = !grant ? cnt_q : grant_wb ? 4'd0 : wb_vld ? cnt_q + 4'd1 : cnt_q;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
`else
   assign grant_wb = wb_vld & ~des_vld;
`endif
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) state_q <= IDLE;
      else state_q <= state_d;
   always_comb state_d = (state_q == IDLE) ? (grant ? ACCESS : IDLE) : (state_q == ACCESS) ? DONE : IDLE;
   // Read data is forwarded straight from the SRAM during the ack cycle and latched for later.
   always_comb begin
      sram_cen_o = state_q != ACCESS;
      sram_gwen_o = !((state_q == ACCESS) && we_q);
      sram_a_o = addr_q;
      sram_d_o = wdata_q;
      des_ack_o = (state_q == DONE) && !owner_q;
      wbs_ack_o = (state_q == DONE) && owner_q;
      des_rdata_o = (des_ack_o && !we_q) ? sram_q_i : des_rdata_q;
      wbs_dat_o = (wbs_ack_o && !we_q) ? sram_q_i : wbs_rdata_q;
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         owner_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         des_rdata_q <= '0;
         wbs_rdata_q <= '0;
      end else begin
         if (grant) begin
            owner_q <= grant_wb;
            we_q <= grant_wb ? wbs_we_i : des_we_i;
            addr_q <= grant_wb ? wbs_adr_i : des_addr_i;
            wdata_q <= grant_wb ? wbs_dat_i : des_wdata_i;
         end
         if (des_ack_o && !we_q) des_rdata_q <= sram_q_i;
         if (wbs_ack_o && !we_q) wbs_rdata_q <= sram_q_i;
      end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter against a behavioural SRAM.
module tb_sram_arbiter;
   logic clk = 0, rst = 1;
   logic des_en, des_req, des_we, wbs_cyc, wbs_stb, wbs_we;
   logic [5:0] des_addr, wbs_adr;
   logic [7:0] des_wdata, wbs_dat_i;
   logic [7:0] des_rdata_o, wbs_dat_o, sram_d_o, sram_q;
   logic des_ack_o, wbs_ack_o, sram_cen_o, sram_gwen_o;
   logic [5:0] sram_a_o;
   logic [7:0] mem [64];
   int errs = 0, checks = 0, both_n = 0, des_acks = 0;
   always #5 clk = ~clk;

   sram_arbiter #(.STARVE_LIMIT(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .des_en_i(des_en), .des_req_i(des_req), .des_we_i(des_we), .des_addr_i(des_addr),
      .des_wdata_i(des_wdata), .des_rdata_o(des_rdata_o), .des_ack_o(des_ack_o),
      .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_adr_i(wbs_adr),
      .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
      .sram_cen_o(sram_cen_o), .sram_gwen_o(sram_gwen_o), .sram_a_o(sram_a_o),
      .sram_d_o(sram_d_o), .sram_q_i(sram_q)
   );

   always @(posedge clk)
      if (!sram_cen_o) begin
         if (!sram_gwen_o) mem[sram_a_o] <= sram_d_o;
         else sram_q <= mem[sram_a_o];
      end

   always @(negedge clk) begin
      if (des_ack_o && wbs_ack_o) both_n++;
      if (des_ack_o) des_acks++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic des_xfer(input logic we, input logic [5:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat, output time t);
      int k = 0;
      des_we = we; des_addr = a; des_wdata = wd; des_req = 1;
      do begin @(negedge clk); k++; end while (!des_ack_o && k < 30);
      if (!des_ack_o) chk("des_timeout", 0, 1);
      lat = k - 1; rd = des_rdata_o; t = $time;
      @(posedge clk); #1 des_req = 0;
   endtask

   task automatic wb_xfer(input logic we, input logic [5:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output time t);
      int k = 0;
      wbs_we = we; wbs_adr = a; wbs_dat_i = wd; wbs_cyc = 1; wbs_stb = 1;
      do begin @(negedge clk); k++; end while (!wbs_ack_o && k < 30);
      if (!wbs_ack_o) chk("wb_timeout", 0, 1);
      lat = k - 1; rd = wbs_dat_o; t = $time;
      @(posedge clk); #1 begin wbs_cyc = 0; wbs_stb = 0; end
   endtask

   initial begin
      logic [7:0] rd_a, rd_b;
      int lat_a, lat_b, n, k, acks0;
      time t_a, t_b;
      des_en = 1; des_req = 0; des_we = 0; des_addr = 0; des_wdata = 0;
      wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_adr = 0; wbs_dat_i = 0;
      step(2);
      chk("rst_cen", sram_cen_o, 1);
      chk("rst_gwen", sram_gwen_o, 1);
      chk("rst_a", sram_a_o, 0);
      chk("rst_d", sram_d_o, 0);
      chk("rst_acks", {des_ack_o, wbs_ack_o}, 0);
      chk("rst_rdata", {des_rdata_o, wbs_dat_o}, 0);
      rst = 0;
      step(1);
      // Wishbone write then read, design idle
      wb_xfer(1, 6'h21, 8'h5A, rd_a, lat_a, t_a);
      chk("wb_wr_lat", lat_a, 2);
      wb_xfer(0, 6'h21, 8'h00, rd_a, lat_a, t_a);
      chk("wb_rd_lat", lat_a, 2);
      chk("wb_rd_data", rd_a, 8'h5A);
      // design write/read, then a write must leave rdata alone
      des_xfer(1, 6'h05, 8'h77, rd_a, lat_a, t_a);
      chk("des_wr_lat", lat_a, 2);
      des_xfer(0, 6'h05, 8'h00, rd_a, lat_a, t_a);
      chk("des_rd_lat", lat_a, 2);
      chk("des_rd_data", rd_a, 8'h77);
      des_xfer(1, 6'h06, 8'h11, rd_a, lat_a, t_a);
      chk("des_rdata_hold", des_rdata_o, 8'h77);
      // simultaneous requests: design first, Wishbone 3 cycles later
      fork
         des_xfer(1, 6'h10, 8'h33, rd_a, lat_a, t_a);
         wb_xfer(0, 6'h21, 8'h00, rd_b, lat_b, t_b);
      join
      chk("conc_des_lat", lat_a, 2);
      chk("conc_gap", 32'(t_b - t_a), 30);
      chk("conc_wb_data", rd_b, 8'h5A);
      // design disabled: its request is ignored
      des_en = 0; des_req = 1; acks0 = des_acks; n = 0;
      repeat (4) begin @(negedge clk); if (!sram_cen_o) n++; end
      chk("dis_cen_idle", n, 0);
      step(1);
      wb_xfer(1, 6'h3F, 8'hC3, rd_a, lat_a, t_a);
      chk("dis_wb_lat", lat_a, 2);
      chk("dis_no_des_ack", des_acks - acks0, 0);
      des_req = 0; des_en = 1;
      // design read at top address
      des_xfer(0, 6'h3F, 8'h00, rd_a, lat_a, t_a);
      chk("wrap_des_data", rd_a, 8'hC3);
      chk("wrap_wb_hold", wbs_dat_o, 8'h5A);
      // continuous design traffic against a pending Wishbone read
      des_we = 0; des_addr = 6'h21; des_req = 1;
      wbs_we = 0; wbs_adr = 6'h21; wbs_cyc = 1; wbs_stb = 1;
      n = 0; k = 0;
`ifdef SRAM_ARB_STARVE_EN
      do begin @(negedge clk); k++; if (des_ack_o) n++; end while (!wbs_ack_o && k < 100);
      chk("starve_wb_ack", wbs_ack_o, 1);
      chk("starve_des_acks", n, 4);
      des_req = 0; wbs_cyc = 0; wbs_stb = 0;
      step(2);
      chk("starve_cnt", 32'(dut.cnt_q), 0);
`else
      do begin @(negedge clk); k++; if (des_ack_o) n++; end while (n < 5 && !wbs_ack_o && k < 100);
      chk("strict_no_wb", wbs_ack_o, 0);
      chk("strict_des_acks", n, 5);
      des_req = 0; k = 0;
      while (!wbs_ack_o && k < 20) begin @(negedge clk); k++; end
      chk("strict_wb_ack", wbs_ack_o, 1);
      wbs_cyc = 0; wbs_stb = 0;
      step(2);
`endif
      // reset in the middle of a design write
      des_we = 1; des_addr = 6'h3F; des_wdata = 8'hEE; des_req = 1;
      step(1);
      chk("mid_cen", sram_cen_o, 0);
      rst = 1; #1;
      chk("mid_rst_cen", sram_cen_o, 1);
      chk("mid_rst_gwen", sram_gwen_o, 1);
      chk("mid_rst_a", sram_a_o, 0);
      chk("mid_rst_state", 32'(dut.state_q), 0);
      chk("mid_rst_ack", des_ack_o, 0);
      chk("mid_rst_rdata", {des_rdata_o, wbs_dat_o}, 0);
      des_req = 0;
      step(1);
      rst = 0; n = 0;
      repeat (5) begin @(negedge clk); if (des_ack_o) n++; end
      chk("mid_no_ack", n, 0);
      step(1);
      des_xfer(0, 6'h3F, 8'h00, rd_a, lat_a, t_a);
      chk("mid_discarded", rd_a, 8'hC3);
      chk("never_both_acks", both_n, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
